ex_pipe_stage: RTL and testbench
================================

Name: ex_pipe_stage

Overview:
Execute stage of the 5-stage pipeline. The block selects the ALU operands through the hazard-unit forwarding muxes and the immediate mux, decodes the ALU operation from alu_op and the instruction word, and computes the result combinationally. It also registers the ALU result and store data into EX/MEM-side registers. It sits between the ID/EX pipeline register and the MEM stage.

Parameters:
DATA_W, 32, datapath width (only 32 is supported)

Ports:
clk  in  1  pipeline clock; rising edge
reset  in  1  asynchronous, active-high reset
id_ex_instr  in  32  instruction in EX; uses opcode [31:26], shamt [10:6], funct [5:0]
reg1  in  32  register-file operand A from ID/EX
reg2  in  32  register-file operand B from ID/EX
id_ex_imm_value  in  32  sign-extended immediate
ex_mem_alu_result  in  32  forwarding source from EX/MEM
mem_wb_write_back_result  in  32  forwarding source from MEM/WB
id_ex_alu_src  in  1  1 = ALU input 2 is the immediate; 0 = forwarded B
id_ex_alu_op  in  2  ALU operation class
Forward_A  in  2  operand A forwarding select
Forward_B  in  2  operand B forwarding select
alu_in2_out  out  32  forwarded B (before the immediate mux), used as store data; combinational
alu_result  out  32  ALU result; combinational
alu_zero  out  1  1 when alu_result == 0; combinational
alu_result_q  out  32  alu_result registered on clk
store_data_q  out  32  alu_in2_out registered on clk

Behaviour:
Forwarding mux (identical for A and B):
- 00 selects reg1 / reg2.
- 10 selects ex_mem_alu_result.
- 01 selects mem_wb_write_back_result.
- 11 is reserved and selects reg1 / reg2.

Operand selection:
- alu_in2_out = forwarded B.
- ALU input 2 = id_ex_alu_src ? id_ex_imm_value : forwarded B.

ALU control:
- alu_op 00: ADD.
- alu_op 01: SUB.
- alu_op 10: R-type; decode funct:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT.
  - 000000 SLL, 000010 SRL, 000011 SRA. Shifts operate on forwarded B, by shamt.
  - Any other funct: ADD.
- alu_op 11: I-type; decode opcode:
  - 001100 AND, 001101 OR, 001110 XOR, 001010 SLT.
  - Any other opcode: ADD.

Arithmetic rules:
- ADD and SUB are modulo 2^32; overflow is ignored with no trap.
- SLT is a signed compare; the result is 1 or 0, zero-extended.
- SRA is arithmetic; SRL and SLL fill with zeros.
- Immediates arrive already sign-extended; logical I-type ops use the value as given.

Timing and registers:
- Combinational outputs have zero latency and reflect inputs within the same cycle.
- On reset assertion (asynchronous), alu_result_q and store_data_q are cleared to 0 immediately. They hold 0 while reset is high.
- On each rising clk edge with reset low, alu_result_q <= alu_result and store_data_q <= alu_in2_out. There is no enable or stall input.
- Reset does not affect the combinational outputs.

Boundary conditions:
- Forwarding select 11 behaves as 00.
- 0x7FFFFFFF + 1 yields 0x80000000.
- Shift by 0 passes the operand through unchanged.
- Reset deassertion mid-cycle: the registers load on the next rising edge.

Test Plan:
- Reset high, then instr 0x20010006 (addi), reg1=2, reg2=42, imm=6, alu_src=1, alu_op=00, Forward_A/B=00 -> alu_result=8, alu_in2_out=42, alu_zero=0. After the first clk with reset low: alu_result_q=8, store_data_q=42.
- Forwarding: reg1=2, ex_mem_alu_result=100, mem_wb_write_back_result=7, alu_src=0, alu_op=00, Forward_A=10, Forward_B=01 -> alu_result=107, alu_in2_out=7. With Forward_A=11: alu_result=2+7=9.
- R-type: alu_op=10, reg1=5, reg2=9, alu_src=0:
  - funct 100010 -> 0xFFFFFFFC.
  - funct 101010 -> 1.
  - funct 100111 -> NOR(5,9)=0xFFFFFFF2.
  - funct 000011 with reg2=0x80000000, shamt=4 -> 0xF8000000.
- I-type: alu_op=11, opcode 001101, reg1=0xF0, imm=0x0F, alu_src=1 -> alu_result=0xFF.
- alu_op=01, reg1=reg2=0x1234 -> alu_result=0, alu_zero=1.
- Assert reset asynchronously between edges while alu_result_q=8 -> alu_result_q and store_data_q go to 0 before the next clk edge. The combinational outputs are unchanged.

Source files
------------

// File: rtl/ex_pipe_stage_if.sv
// rtl/ex_pipe_stage_if.sv - ID/EX operand, forwarding and ALU result bundle for the execute stage
interface ex_pipe_stage_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       id_ex_instr;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;
  logic [DATA_W-1:0] id_ex_imm_value;
  logic [DATA_W-1:0] ex_mem_alu_result;
  logic [DATA_W-1:0] mem_wb_write_back_result;
  logic              id_ex_alu_src;
  logic [1:0]        id_ex_alu_op;
  logic [1:0]        Forward_A;
  logic [1:0]        Forward_B;
  logic [DATA_W-1:0] alu_in2_out;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic [DATA_W-1:0] alu_result_q;
  logic [DATA_W-1:0] store_data_q;

  modport master (
    output id_ex_instr, reg1, reg2, id_ex_imm_value, ex_mem_alu_result,
           mem_wb_write_back_result, id_ex_alu_src, id_ex_alu_op, Forward_A, Forward_B,
    input  alu_in2_out, alu_result, alu_zero, alu_result_q, store_data_q
  );

  modport slave (
    input  id_ex_instr, reg1, reg2, id_ex_imm_value, ex_mem_alu_result,
           mem_wb_write_back_result, id_ex_alu_src, id_ex_alu_op, Forward_A, Forward_B,
    output alu_in2_out, alu_result, alu_zero, alu_result_q, store_data_q
  );
endinterface

// File: rtl/ex_pipe_stage.sv
// rtl/ex_pipe_stage.sv - execute stage: forwarding muxes, ALU decode/compute, EX/MEM result registers
module ex_pipe_stage #(
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  ex_pipe_stage_if.slave  bus
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_ctl_t;

  // Select 11 is reserved and falls back to the register-file value
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] rf_val,
    input logic [DATA_W-1:0] ex_mem_val,
    input logic [DATA_W-1:0] mem_wb_val
  );
    case (sel)
      2'b10:   fwd_sel = ex_mem_val;
      2'b01:   fwd_sel = mem_wb_val;
      default: fwd_sel = rf_val;
    endcase
  endfunction

  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;
  logic [DATA_W-1:0] w_alu_in2;
  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic [4:0]        w_shamt;
  logic              w_unused_instr;
  alu_ctl_t          w_alu_ctl;
  logic [DATA_W-1:0] w_alu_result;
  logic [DATA_W-1:0] r_alu_result_q;
  logic [DATA_W-1:0] r_store_data_q;

  assign w_opcode       = bus.id_ex_instr[31:26];
  assign w_shamt        = bus.id_ex_instr[10:6];
  assign w_funct        = bus.id_ex_instr[5:0];
  assign w_unused_instr = &{1'b0, bus.id_ex_instr[25:11]};

  assign w_fwd_a   = fwd_sel(bus.Forward_A, bus.reg1, bus.ex_mem_alu_result,
                             bus.mem_wb_write_back_result);
  assign w_fwd_b   = fwd_sel(bus.Forward_B, bus.reg2, bus.ex_mem_alu_result,
                             bus.mem_wb_write_back_result);
  assign w_alu_in2 = bus.id_ex_alu_src ? bus.id_ex_imm_value : w_fwd_b;

  always_comb begin
    w_alu_ctl = ALU_ADD;
    case (bus.id_ex_alu_op)
      2'b01: w_alu_ctl = ALU_SUB;
      2'b10: begin
        case (w_funct)
          6'b100010: w_alu_ctl = ALU_SUB;
          6'b100100: w_alu_ctl = ALU_AND;
          6'b100101: w_alu_ctl = ALU_OR;
          6'b100110: w_alu_ctl = ALU_XOR;
          6'b100111: w_alu_ctl = ALU_NOR;
          6'b101010: w_alu_ctl = ALU_SLT;
          6'b000000: w_alu_ctl = ALU_SLL;
          6'b000010: w_alu_ctl = ALU_SRL;
          6'b000011: w_alu_ctl = ALU_SRA;
          default:   w_alu_ctl = ALU_ADD;
        endcase
      end
      2'b11: begin
        case (w_opcode)
          6'b001100: w_alu_ctl = ALU_AND;
          6'b001101: w_alu_ctl = ALU_OR;
          6'b001110: w_alu_ctl = ALU_XOR;
          6'b001010: w_alu_ctl = ALU_SLT;
          default:   w_alu_ctl = ALU_ADD;
        endcase
      end
      default: w_alu_ctl = ALU_ADD;
    endcase
  end

  // Shifts take the forwarded B operand, never the immediate
  always_comb begin
    w_alu_result = w_fwd_a + w_alu_in2;
    case (w_alu_ctl)
      ALU_SUB: w_alu_result = w_fwd_a - w_alu_in2;
      ALU_AND: w_alu_result = w_fwd_a & w_alu_in2;
      ALU_OR:  w_alu_result = w_fwd_a | w_alu_in2;
      ALU_XOR: w_alu_result = w_fwd_a ^ w_alu_in2;
      ALU_NOR: w_alu_result = ~(w_fwd_a | w_alu_in2);
      ALU_SLT: w_alu_result = {{(DATA_W-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_alu_in2))};
      ALU_SLL: w_alu_result = w_fwd_b << w_shamt;
      ALU_SRL: w_alu_result = w_fwd_b >> w_shamt;
      ALU_SRA: w_alu_result = $unsigned($signed(w_fwd_b) >>> w_shamt);
      default: w_alu_result = w_fwd_a + w_alu_in2;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_result_q <= '0;
      r_store_data_q <= '0;
    end else begin
      r_alu_result_q <= w_alu_result;
      r_store_data_q <= w_fwd_b;
    end
  end

  assign bus.alu_in2_out  = w_fwd_b;
  assign bus.alu_result   = w_alu_result;
  assign bus.alu_zero     = (w_alu_result == '0);
  assign bus.alu_result_q = r_alu_result_q;
  assign bus.store_data_q = r_store_data_q;

endmodule

// File: tb/tb_ex_pipe_stage.sv
// tb/tb_ex_pipe_stage.sv - self-checking bench for ex_pipe_stage against a behavioural ALU model
module tb_ex_pipe_stage;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  ex_pipe_stage_if bus ();

  ex_pipe_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk_instr(input logic [5:0] opc, input logic [4:0] sh,
                                           input logic [5:0] fn);
    mk_instr = {opc, 15'd0, sh, fn};
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                          input logic [31:0] exm, input logic [31:0] mwb);
    if (sel == 2'b10)      ref_fwd = exm;
    else if (sel == 2'b01) ref_fwd = mwb;
    else                   ref_fwd = rf;
  endfunction

  function automatic string ref_op(input logic [1:0] op, input logic [31:0] instr);
    logic [5:0] opc;
    logic [5:0] fn;
    opc = instr[31:26];
    fn  = instr[5:0];
    ref_op = "ADD";
    if (op == 2'b01) ref_op = "SUB";
    else if (op == 2'b10) begin
      if      (fn == 6'b100010) ref_op = "SUB";
      else if (fn == 6'b100100) ref_op = "AND";
      else if (fn == 6'b100101) ref_op = "OR";
      else if (fn == 6'b100110) ref_op = "XOR";
      else if (fn == 6'b100111) ref_op = "NOR";
      else if (fn == 6'b101010) ref_op = "SLT";
      else if (fn == 6'b000000) ref_op = "SLL";
      else if (fn == 6'b000010) ref_op = "SRL";
      else if (fn == 6'b000011) ref_op = "SRA";
    end else if (op == 2'b11) begin
      if      (opc == 6'b001100) ref_op = "AND";
      else if (opc == 6'b001101) ref_op = "OR";
      else if (opc == 6'b001110) ref_op = "XOR";
      else if (opc == 6'b001010) ref_op = "SLT";
    end
  endfunction

  function automatic logic [31:0] ref_result(input logic [31:0] instr, input logic [31:0] a,
                                             input logic [31:0] fb, input logic [31:0] b,
                                             input logic [1:0] op);
    string s;
    int    sh;
    logic [31:0] ones;
    s    = ref_op(op, instr);
    sh   = int'(instr[10:6]);
    ones = 32'hFFFF_FFFF;
    case (s)
      "SUB": ref_result = a - b;
      "AND": ref_result = a & b;
      "OR":  ref_result = a | b;
      "XOR": ref_result = a ^ b;
      "NOR": ref_result = ~(a | b);
      "SLT": ref_result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      "SLL": ref_result = fb << sh;
      "SRL": ref_result = fb >> sh;
      "SRA": ref_result = (fb >> sh) | (fb[31] ? ~(ones >> sh) : 32'd0);
      default: ref_result = a + b;
    endcase
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] imm, input logic [31:0] exm, input logic [31:0] mwb,
                       input logic src, input logic [1:0] op, input logic [1:0] fa,
                       input logic [1:0] fb);
    bus.id_ex_instr              = instr;
    bus.reg1                     = r1;
    bus.reg2                     = r2;
    bus.id_ex_imm_value          = imm;
    bus.ex_mem_alu_result        = exm;
    bus.mem_wb_write_back_result = mwb;
    bus.id_ex_alu_src            = src;
    bus.id_ex_alu_op             = op;
    bus.Forward_A                = fa;
    bus.Forward_B                = fb;
  endtask

  task automatic chk_comb(input string name, input logic [31:0] res, input logic [31:0] in2,
                          input logic zero);
    checks++;
    if (bus.alu_result !== res) begin
      errors++;
      $display("FAIL %s alu_result: got %h expected %h", name, bus.alu_result, res);
    end
    checks++;
    if (bus.alu_in2_out !== in2) begin
      errors++;
      $display("FAIL %s alu_in2_out: got %h expected %h", name, bus.alu_in2_out, in2);
    end
    checks++;
    if (bus.alu_zero !== zero) begin
      errors++;
      $display("FAIL %s alu_zero: got %b expected %b", name, bus.alu_zero, zero);
    end
  endtask

  task automatic chk_regs(input string name, input logic [31:0] res_q, input logic [31:0] st_q);
    checks++;
    if (bus.alu_result_q !== res_q) begin
      errors++;
      $display("FAIL %s alu_result_q: got %h expected %h", name, bus.alu_result_q, res_q);
    end
    checks++;
    if (bus.store_data_q !== st_q) begin
      errors++;
      $display("FAIL %s store_data_q: got %h expected %h", name, bus.store_data_q, st_q);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(32'h2001_0006, 32'd2, 32'd42, 32'd6, 32'd0, 32'd0, 1'b1, 2'b00, 2'b00, 2'b00);
    #1;
    chk_regs("reset_async", 32'd0, 32'd0);
    @(posedge clk); #1;
    chk_regs("reset_held", 32'd0, 32'd0);
    chk_comb("addi_in_reset", 32'd8, 32'd42, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk_regs("addi_first_edge", 32'd8, 32'd42);
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    drive(32'h0, 32'd2, 32'd55, 32'd0, 32'd100, 32'd7, 1'b0, 2'b00, 2'b10, 2'b01);
    #1;
    chk_comb("fwd_10_01", 32'd107, 32'd7, 1'b0);
    bus.Forward_A = 2'b11;
    #1;
    chk_comb("fwd_a_11", 32'd9, 32'd7, 1'b0);
    bus.Forward_B = 2'b11;
    #1;
    chk_comb("fwd_b_11", 32'd57, 32'd55, 1'b0);
    @(posedge clk); #1;
    chk_regs("fwd_regs", 32'd57, 32'd55);
  endtask

  task automatic test_rtype();
    @(negedge clk);
    drive(mk_instr(6'd0, 5'd0, 6'b100010), 32'd5, 32'd9, 32'd0, 32'd0, 32'd0, 1'b0, 2'b10, 2'b00, 2'b00);
    #1 chk_comb("r_sub", 32'hFFFF_FFFC, 32'd9, 1'b0);
    bus.id_ex_instr = mk_instr(6'd0, 5'd0, 6'b101010);
    #1 chk_comb("r_slt", 32'd1, 32'd9, 1'b0);
    bus.id_ex_instr = mk_instr(6'd0, 5'd0, 6'b100111);
    #1 chk_comb("r_nor", 32'hFFFF_FFF2, 32'd9, 1'b0);
    bus.id_ex_instr = mk_instr(6'd0, 5'd4, 6'b000011);
    bus.reg2 = 32'h8000_0000;
    #1 chk_comb("r_sra", 32'hF800_0000, 32'h8000_0000, 1'b0);
  endtask

  task automatic test_itype_sub();
    @(negedge clk);
    drive(mk_instr(6'b001101, 5'd0, 6'd0), 32'hF0, 32'd3, 32'h0F, 32'd0, 32'd0, 1'b1, 2'b11, 2'b00, 2'b00);
    #1 chk_comb("i_ori", 32'hFF, 32'd3, 1'b0);
    drive(32'h0, 32'h1234, 32'h1234, 32'd0, 32'd0, 32'd0, 1'b0, 2'b01, 2'b00, 2'b00);
    #1 chk_comb("sub_zero", 32'd0, 32'h1234, 1'b1);
  endtask

  task automatic test_boundary();
    @(negedge clk);
    drive(32'h0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 2'b00);
    #1 chk_comb("add_overflow", 32'h8000_0000, 32'd1, 1'b0);
    drive(mk_instr(6'd0, 5'd0, 6'b000011), 32'd0, 32'hA5A5_0F0F, 32'd0, 32'd0, 32'd0, 1'b0, 2'b10, 2'b00, 2'b00);
    #1 chk_comb("sra_by_0", 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b0);
    bus.id_ex_instr = mk_instr(6'd0, 5'd0, 6'b000000);
    #1 chk_comb("sll_by_0", 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b0);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(32'h2001_0006, 32'd2, 32'd42, 32'd6, 32'd0, 32'd0, 1'b1, 2'b00, 2'b00, 2'b00);
    @(posedge clk); #1;
    chk_regs("pre_async", 32'd8, 32'd42);
    #1 reset = 1'b1;
    #1;
    chk_regs("async_assert", 32'd0, 32'd0);
    chk_comb("async_comb", 32'd8, 32'd42, 1'b0);
    @(posedge clk); #1;
    chk_regs("async_hold", 32'd0, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk_regs("deassert_wait", 32'd0, 32'd0);
    @(posedge clk); #1;
    chk_regs("deassert_load", 32'd8, 32'd42);
  endtask

  task automatic test_random();
    logic [5:0]  functs [10];
    logic [5:0]  opcs [4];
    logic [31:0] instr, r1, r2, imm, exm, mwb, a, fbv, b, exp_res;
    logic [1:0]  op, fa, fb;
    logic        src;
    logic [5:0]  fn, opc;
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
               6'b100111, 6'b101010, 6'b000000, 6'b000010, 6'b000011};
    opcs   = '{6'b001100, 6'b001101, 6'b001110, 6'b001010};
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      fn  = ($urandom_range(0, 11) < 10) ? functs[$urandom_range(0, 9)] : 6'($urandom);
      opc = ($urandom_range(0, 5) < 4) ? opcs[$urandom_range(0, 3)] : 6'($urandom);
      instr = mk_instr(opc, 5'($urandom), fn);
      r1  = $urandom; r2 = $urandom; imm = $urandom; exm = $urandom; mwb = $urandom;
      if (i % 7 == 0) r2 = r1;
      src = 1'($urandom); op = 2'($urandom); fa = 2'($urandom); fb = 2'($urandom);
      drive(instr, r1, r2, imm, exm, mwb, src, op, fa, fb);
      a       = ref_fwd(fa, r1, exm, mwb);
      fbv     = ref_fwd(fb, r2, exm, mwb);
      b       = src ? imm : fbv;
      exp_res = ref_result(instr, a, fbv, b, op);
      #1 chk_comb("random", exp_res, fbv, exp_res == 32'd0);
      @(posedge clk); #1;
      chk_regs("random_regs", exp_res, fbv);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_forwarding();
    test_rtype();
    test_itype_sub();
    test_boundary();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
